// File: rtl/manchester_to_nrz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_to_nrz_pkg
//  Description : Manchester line-code constants, half-bit phase encoding and
//                pair helpers for the Manchester -> NRZ decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package manchester_to_nrz_pkg;

    // Legal Manchester half-bit pairs, written {first half, second half}
    localparam logic [1:0] c_man_hi_lo = 2'b10;
    localparam logic [1:0] c_man_lo_hi = 2'b01;

    // Which half of a Manchester bit the next sample belongs to
    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    // A pair is legal only if it carries a mid-bit transition
    function automatic logic man_pair_valid(input logic [1:0] pair);
        return (pair == c_man_hi_lo) || (pair == c_man_lo_hi);
    endfunction

    // IEEE 802.3 maps 01 -> 1, so the bit is the second half; G.E. Thomas
    // inverts that mapping
    function automatic logic man_decode(input logic [1:0] pair, input logic pol);
        return pair[0] ^ pol;
    endfunction

endpackage : manchester_to_nrz_pkg
`default_nettype wire

// File: rtl/manchester_to_nrz.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_to_nrz
//  Description : Decodes a Manchester half-bit stream (two clk per bit) to
//                NRZ, hunts bit phase by slipping one half-bit on each code
//                violation, and reports lock and violation statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module manchester_to_nrz
    import manchester_to_nrz_pkg::*;
#(
    parameter int LOCK_COUNT = 4,   // valid pairs in a row before lock (1..15)
    parameter int POLARITY   = 0,   // 0: IEEE 802.3, 1: G.E. Thomas
    parameter int ERR_W      = 8    // violation counter width
) (
    input  logic             clk,
    input  logic             reset,          // asynchronous, active-low
    input  logic             Manchester_in,
    output logic             NRZ_out,
    output logic             NRZ_valid,
    output logic             locked,
    output logic             code_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0]       c_lock_target = 4'(LOCK_COUNT);
    localparam logic             c_pol         = (POLARITY != 0);
    localparam logic [ERR_W-1:0] c_err_max     = {ERR_W{1'b1}};

    phase_t     r_phase;
    logic       r_first_q;
    logic [3:0] r_lock_cnt;

    logic [1:0] w_pair;
    logic       w_pair_ok;
    logic       w_good_pair;
    logic       w_bad_pair;
    logic [3:0] w_lock_cnt_next;

    // A pair is only judged while the second half is being presented
    assign w_pair      = {r_first_q, Manchester_in};
    assign w_pair_ok   = man_pair_valid(w_pair);
    assign w_good_pair = (r_phase == PH_SECOND) &&  w_pair_ok;
    assign w_bad_pair  = (r_phase == PH_SECOND) && !w_pair_ok;

    // Lock run length saturates at the target so it can never wrap
    assign w_lock_cnt_next = (r_lock_cnt < c_lock_target) ? (r_lock_cnt + 4'd1)
                                                          : r_lock_cnt;

    // Phase FSM: capture first half, then decode or slip by one half-bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase   <= PH_FIRST;
            r_first_q <= 1'b0;
            NRZ_out   <= 1'b0;
            NRZ_valid <= 1'b0;
            code_err  <= 1'b0;
        end else begin
            NRZ_valid <= 1'b0;
            code_err  <= 1'b0;
            case (r_phase)
                PH_FIRST: begin
                    r_first_q <= Manchester_in;
                    r_phase   <= PH_SECOND;
                end
                PH_SECOND: begin
                    if (w_pair_ok) begin
                        NRZ_out   <= man_decode(w_pair, c_pol);
                        NRZ_valid <= 1'b1;
                        r_phase   <= PH_FIRST;
                    end else begin
                        // Treat the current sample as a new first half and
                        // stay in SECOND: a one half-bit slip
                        code_err  <= 1'b1;
                        r_first_q <= Manchester_in;
                    end
                end
                default: r_phase <= PH_FIRST;
            endcase
        end
    end

    // Lock tracking and saturating violation counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lock_cnt <= 4'd0;
            locked     <= 1'b0;
            err_count  <= '0;
        end else if (w_good_pair) begin
            r_lock_cnt <= w_lock_cnt_next;
            if (w_lock_cnt_next == c_lock_target) begin
                locked <= 1'b1;
            end
        end else if (w_bad_pair) begin
            r_lock_cnt <= 4'd0;
            locked     <= 1'b0;
            // Only violations seen while already locked are counted
            if (locked && (err_count != c_err_max)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule : manchester_to_nrz
`default_nettype wire

// File: tb/tb_manchester_to_nrz.sv
`default_nettype none
// ============================================================================
//  Module      : tb_manchester_to_nrz
//  Description : Self-checking bench for manchester_to_nrz: vector table for
//                reset, alignment, slip and relock; scoreboard for a random
//                encoded stream; hand sequences for saturation and POLARITY=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_manchester_to_nrz;

    logic       clk;
    logic       rst0, rst1;
    logic       man0, man1;
    logic       nrz0, nrz1;
    logic       val0, val1;
    logic       lk0, lk1;
    logic       err0, err1;
    logic [7:0] ecnt0, ecnt1;

    int checks   = 0;
    int failures = 0;

    manchester_to_nrz #(.LOCK_COUNT(4), .POLARITY(0), .ERR_W(8)) u_dut0 (
        .clk(clk), .reset(rst0), .Manchester_in(man0),
        .NRZ_out(nrz0), .NRZ_valid(val0), .locked(lk0),
        .code_err(err0), .err_count(ecnt0)
    );

    manchester_to_nrz #(.LOCK_COUNT(4), .POLARITY(1), .ERR_W(8)) u_dut1 (
        .clk(clk), .reset(rst1), .Manchester_in(man1),
        .NRZ_out(nrz1), .NRZ_valid(val1), .locked(lk1),
        .code_err(err1), .err_count(ecnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_before;
        logic       din;
        logic       v;
        logic       nrz;
        logic       err;
        logic       lk;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[$];
    logic exp_q[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic d, input logic v, input logic n,
                       input logic e, input logic l, input logic [7:0] c);
        vec_t t;
        t.rst_before = r; t.din = d; t.v = v; t.nrz = n;
        t.err = e; t.lk = l; t.ecnt = c;
        tbl.push_back(t);
    endtask

    task automatic reset_dut0();
        man0 = 1'b0;
        #2 rst0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b1;
    endtask

    // Drive one half-bit into dut0, check 1 time unit after the edge
    task automatic half0(input logic b);
        man0 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic half1(input logic b);
        man1 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic b;
        logic held;
        logic [7:0] e_before;

        rst0 = 1'b0; rst1 = 1'b0; man0 = 1'b0; man1 = 1'b0;

        // Reset held: outputs stay zero while the input toggles
        for (int i = 0; i < 4; i++) begin
            half0(~man0);
            check("rst_outs", i, {nrz0, val0, lk0, err0, ecnt0}, 32'd0);
        end

        // Aligned stream 10 01 01 10 01, then 00 violation while locked, relock
        add(1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1);
        add(0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1, 1);
        // Misaligned start: extra '1' then 10 10 01
        add(1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) reset_dut0();
            half0(tbl[i].din);
            check("vec_valid",  i, val0,  tbl[i].v);
            check("vec_nrz",    i, nrz0,  tbl[i].nrz);
            check("vec_err",    i, err0,  tbl[i].err);
            check("vec_locked", i, lk0,   tbl[i].lk);
            check("vec_errcnt", i, ecnt0, tbl[i].ecnt);
        end

        // Random NRZ encoded in the bench, decoded bits checked via scoreboard
        reset_dut0();
        for (int i = 0; i < 40; i++) begin
            b = 1'($urandom_range(0, 1));
            half0(~b);
            check("rand_err_h1", i, err0, 1'b0);
            if (val0) check("rand_spurious_valid", i, 1'b1, 1'b0);
            exp_q.push_back(b);
            half0(b);
            check("rand_err_h2", i, err0, 1'b0);
            if (val0) begin
                if (exp_q.size() == 0) check("rand_empty_q", i, 1'b1, 1'b0);
                else check("rand_bit", i, nrz0, exp_q.pop_front());
            end
        end
        check("rand_q_drained", 0, exp_q.size(), 0);
        check("rand_locked", 0, lk0, 1'b1);

        // Constant '1' while locked: one counted violation, errors every cycle
        held = nrz0;
        e_before = ecnt0;
        half0(1'b1);
        check("const_first_err", 0, err0, 1'b0);
        for (int i = 1; i < 600; i++) begin
            half0(1'b1);
            check("const_err", i, err0, 1'b1);
            check("const_valid", i, val0, 1'b0);
        end
        check("const_nrz_hold", 0, nrz0, held);
        check("const_locked", 0, lk0, 1'b0);
        check("const_errcnt", 0, ecnt0, e_before + 8'd1);

        // Saturation: repeated lock / violation rounds
        reset_dut0();
        for (int i = 0; i < 4; i++) begin half0(1'b0); half0(1'b1); end
        check("sat_lock0", 0, lk0, 1'b1);
        half0(1'b0); half0(1'b0);
        check("sat_cnt1", 0, ecnt0, 8'd1);
        for (int k = 2; k <= 260; k++) begin
            half0(1'b1);
            for (int i = 0; i < 3; i++) begin half0(1'b0); half0(1'b1); end
            check("sat_relock", k, lk0, 1'b1);
            half0(1'b0); half0(1'b0);
            if (k == 255) check("sat_cnt255", k, ecnt0, 8'd255);
        end
        check("sat_hold", 0, ecnt0, 8'd255);

        // POLARITY=1: 01 -> 0, 10 -> 1; reset between halves drops the bit
        @(negedge clk);
        rst1 = 1'b1;
        half1(1'b0);
        half1(1'b1);
        check("pol1_v0", 0, val1, 1'b1);
        check("pol1_b0", 0, nrz1, 1'b0);
        half1(1'b1);
        half1(1'b0);
        check("pol1_v1", 0, val1, 1'b1);
        check("pol1_b1", 0, nrz1, 1'b1);
        half1(1'b0);
        rst1 = 1'b0;
        #1;
        check("pol1_async_rst", 0, {nrz1, val1, err1}, 3'b000);
        man1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pol1_in_rst_valid", 0, val1, 1'b0);
        @(negedge clk);
        rst1 = 1'b1;
        half1(1'b1);
        check("pol1_after_rst_valid", 0, val1, 1'b0);
        check("pol1_after_rst_err", 0, err1, 1'b0);
        half1(1'b0);
        check("pol1_rehunt_valid", 0, val1, 1'b1);
        check("pol1_rehunt_bit", 0, nrz1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_manchester_to_nrz
`default_nettype wire
